// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
// Holds the control state encoding and the iteration counter width helper.
// No logic of its own; imported by the multiplier and its sub-modules.
package seq_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Operand magnitude: two's complement absolute value in signed mode, pass-through otherwise.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module seq_mult_abs #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] magnitude
);

    // The most negative value negates to 2^(WIDTH-1), which still fits unsigned.
    assign magnitude = (signed_mode && value[WIDTH-1]) ? -value : value;

endmodule

// File: rtl/seq_mult_param.sv
// Shift-add sequential multiplier, signed or unsigned per operation, optional early exit.
// Latency: done pulses WIDTH+2 edges after the accepting edge counting it (fewer with EARLY_EXIT).
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, abort cancels.
module seq_mult_param #(
    parameter int WIDTH      = 6,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    import seq_arith_pkg::*;

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             accept;
    logic             last_iter;

    seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value       (a),
        .signed_mode (signed_mode),
        .magnitude   (mag_a)
    );

    seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value       (b),
        .signed_mode (signed_mode),
        .magnitude   (mag_b)
    );

    // Early exit looks at the multiplier as it will be after this edge's shift.
    assign last_iter = (cnt == CW'(WIDTH - 1)) ||
                       (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (!abort) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    // Abort takes priority: the previous product is kept.
                    if (!abort) begin
                        product <= neg ? -acc : acc;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: three configurations (6-bit, 8-bit, 8-bit early exit)
// driven by directed steps and random operands against an arithmetic reference.
module tb_seq_mult_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        st0, sm0, ab0, busy0, done0;
    logic [5:0]  a0, b0;
    logic [11:0] p0;
    logic        st1, sm1, ab1, busy1, done1;
    logic [7:0]  a1, b1;
    logic [15:0] p1;
    logic        st2, sm2, ab2, busy2, done2;
    logic [7:0]  a2, b2;
    logic [15:0] p2;

    seq_mult_param #(.WIDTH(6), .EARLY_EXIT(1'b0)) u_w6 (
        .clk(clk), .rst(rst), .start(st0), .signed_mode(sm0), .a(a0), .b(b0),
        .abort(ab0), .busy(busy0), .done(done0), .product(p0));

    seq_mult_param #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .start(st1), .signed_mode(sm1), .a(a1), .b(b1),
        .abort(ab1), .busy(busy1), .done(done1), .product(p1));

    seq_mult_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e (
        .clk(clk), .rst(rst), .start(st2), .signed_mode(sm2), .a(a2), .b(b2),
        .abort(ab2), .busy(busy2), .done(done2), .product(p2));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed/unsigned full product reduced to 2w bits.
    function automatic logic [63:0] model(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, mask;
        sa = longint'(a) & ((longint'(1) << w) - 1);
        sb = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p    = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(p & mask);
    endfunction

    // Early-exit timing: one iteration per significant bit of |b| (at least one), plus FIX.
    function automatic int model_ee_lat(input int w, input bit sm, input logic [31:0] b);
        longint sb;
        int n;
        sb = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && b[w-1]) sb = (longint'(1) << w) - sb;
        n = 0;
        while (sb != 0) begin
            sb = sb >> 1;
            n++;
        end
        if (n == 0) n = 1;
        return n + 1;
    endfunction

    function automatic logic get_done(input int s);
        case (s)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [63:0] get_prod(input int s);
        case (s)
            0:       return 64'(p0);
            1:       return 64'(p1);
            default: return 64'(p2);
        endcase
    endfunction

    task automatic drive(input int s, input bit st, input bit sm, input logic [31:0] a,
                         input logic [31:0] b, input bit abt);
        case (s)
            0: begin st0 = st; sm0 = sm; a0 = a[5:0]; b0 = b[5:0]; ab0 = abt; end
            1: begin st1 = st; sm1 = sm; a1 = a[7:0]; b1 = b[7:0]; ab1 = abt; end
            default: begin st2 = st; sm2 = sm; a2 = a[7:0]; b2 = b[7:0]; ab2 = abt; end
        endcase
    endtask

    // One start pulse; lat = edges after the accepting edge until done is seen.
    task automatic op(input int s, input bit sm, input logic [31:0] a, input logic [31:0] b,
                      output logic [63:0] prod, output int lat, output int busyc);
        @(negedge clk);
        drive(s, 1'b1, sm, a, b, 1'b0);
        @(negedge clk);
        drive(s, 1'b0, sm, a, b, 1'b0);
        lat   = 0;
        busyc = 0;
        while (!get_done(s) && lat < 200) begin
            if (get_busy(s)) busyc++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", 64'(get_done(s)), 64'd1);
        prod = get_prod(s);
    endtask

    initial begin
        logic [63:0] prod;
        int          lat, bc, d1, d2, seen;
        bit          sm;
        logic [31:0] ra, rb;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0, 0);
        #12;
        check("rst_p6", 64'(p0), 64'd0);
        check("rst_busy6", 64'(busy0), 64'd0);
        check("rst_done6", 64'(done0), 64'd0);
        check("rst_p8", 64'(p1), 64'd0);
        check("rst_p8e", 64'(p2), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        op(0, 1'b0, 32'd45, 32'd27, prod, lat, bc);
        check("u6_45x27", prod, 64'd1215);
        check("u6_lat", 64'(lat), 64'd7);
        check("u6_busy_cycles", 64'(bc), 64'd7);
        @(negedge clk);
        check("done_one_cycle", 64'(done0), 64'd0);
        check("idle_after_done", 64'(busy0), 64'd0);

        op(0, 1'b1, 32'h20, 32'h20, prod, lat, bc);
        check("s6_min_sq", prod, 64'd1024);
        op(0, 1'b1, 32'h20, 32'd31, prod, lat, bc);
        check("s6_min_x31", prod, 64'hC20);
        op(0, 1'b1, 32'h3F, 32'd1, prod, lat, bc);
        check("s6_m1x1", prod, 64'hFFF);

        op(1, 1'b0, 32'hFF, 32'hFF, prod, lat, bc);
        check("u8_ffxff", prod, 64'hFE01);
        check("u8_lat", 64'(lat), 64'd9);
        op(1, 1'b1, 32'hFF, 32'hFF, prod, lat, bc);
        check("s8_ffxff", prod, 64'h0001);

        // Start pulse while running must be ignored.
        @(negedge clk);
        drive(0, 1, 0, 5, 7, 0);
        @(negedge clk);
        drive(0, 0, 0, 5, 7, 0);
        @(negedge clk);
        drive(0, 1, 0, 9, 9, 0);
        @(negedge clk);
        drive(0, 0, 0, 9, 9, 0);
        lat = 0;
        while (!done0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("ignored_start_prod", 64'(p0), 64'd35);
        op(0, 1'b0, 32'd9, 32'd9, prod, lat, bc);
        check("second_start_prod", prod, 64'd81);

        // Held start: one operation per WIDTH+2 cycles.
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        drive(0, 1, 0, 3, 5, 0);
        for (int k = 0; k < 40 && d2 < 0; k++) begin
            @(negedge clk);
            if (done0) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
        end
        drive(0, 0, 0, 3, 5, 0);
        check("b2b_spacing", 64'(d2 - d1), 64'd8);
        check("b2b_prod", 64'(p0), 64'd15);
        repeat (3) @(negedge clk);

        // Abort on the third RUN edge.
        op(0, 1'b0, 32'd10, 32'd10, prod, lat, bc);
        check("pre_abort_prod", prod, 64'd100);
        @(negedge clk);
        drive(0, 1, 0, 7, 9, 0);
        @(negedge clk);
        drive(0, 0, 0, 7, 9, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 7, 9, 1);
        @(negedge clk);
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_done", 64'(done0), 64'd0);
        drive(0, 0, 0, 7, 9, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_prod_kept", 64'(p0), 64'd100);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        drive(0, 1, 0, 5, 5, 0);
        @(negedge clk);
        drive(0, 0, 0, 5, 5, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_prod", 64'(p0), 64'd0);
        check("arst_busy", 64'(busy0), 64'd0);
        check("arst_prod8", 64'(p1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        op(0, 1'b0, 32'd3, 32'd4, prod, lat, bc);
        check("post_rst_prod", prod, 64'd12);
        check("post_rst_lat", 64'(lat), 64'd7);

        op(2, 1'b0, 32'd10, 32'd3, prod, lat, bc);
        check("ee_10x3", prod, 64'd30);
        check("ee_10x3_lat", 64'(lat), 64'd3);
        op(2, 1'b0, 32'd10, 32'd0, prod, lat, bc);
        check("ee_b0", prod, 64'd0);
        check("ee_b0_lat", 64'(lat), 64'd2);

        for (int i = 0; i < 20; i++) begin
            sm = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            op(0, sm, ra, rb, prod, lat, bc);
            check("rand6", prod, model(6, sm, ra, rb));
            check("rand6_lat", 64'(lat), 64'd7);
        end
        for (int i = 0; i < 12; i++) begin
            sm = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            op(1, sm, ra, rb, prod, lat, bc);
            check("rand8", prod, model(8, sm, ra, rb));
        end
        for (int i = 0; i < 16; i++) begin
            sm = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            op(2, sm, ra, rb, prod, lat, bc);
            check("rand8e", prod, model(8, sm, ra, rb));
            check("rand8e_lat", 64'(lat), 64'(model_ee_lat(8, sm, rb)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
